pe_link_tx: RTL and testbench
=============================

PE_LINK_TX -- requirements
Module: pe_link_tx

Interface
REQ-001 SHALL have parameter LINK_WIDTH, default 130: width of the inter-PE link word.
REQ-002 SHALL have parameter FIFO_AW, default 2: log2 of the ingress FIFO depth (depth 4).
REQ-003 SHALL have parameter CREDITS, default 4: receiver slots available after reset.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port ap_start, input, 1: high enables launching new packets.
REQ-007 SHALL have port in_data, input, LINK_WIDTH-2: payload word from the PE core.
REQ-008 SHALL have port in_last, input, 1: marks the final word of a packet.
REQ-009 SHALL have port in_valid, input, 1: in_data/in_last are valid.
REQ-010 SHALL have port in_ready, output, 1: the FIFO can accept a word.
REQ-011 SHALL have port credit_in, input, 1: one-cycle pulse, meaning the receiver freed one slot.
REQ-012 SHALL have port out_link, output, LINK_WIDTH: registered link word driven to out_to_east/west/south.
REQ-013 SHALL have port busy, output, 1: the FIFO is non-empty or the FSM is in PKT.
REQ-014 SHALL have port credit_err, output, 1: sticky flag for a credit overflow.
REQ-015 SHALL have port tx_count, output, 32: number of words sent.

Function
REQ-016 Link format SHALL be: bit LINK_WIDTH-1 = valid; bit LINK_WIDTH-2 = last; bits LINK_WIDTH-3:0 = payload.
REQ-017 in_ready SHALL be the inverse of FIFO full; a word SHALL be written when in_valid and in_ready are both high at a rising edge.
REQ-018 A send SHALL occur in a cycle when the FIFO is non-empty, credit count > 0 and the FSM permits (REQ-021).
REQ-019 On a send, out_link SHALL register {1, last, payload} from the FIFO head, and the head SHALL be popped.
REQ-020 In a cycle with no send, out_link SHALL register all zeros, so the valid bit is high for exactly one cycle per word.
REQ-021 FSM states SHALL be IDLE and PKT:
- IDLE: a send is permitted only when ap_start = 1; a send of a non-last word SHALL go to PKT.
- PKT: sends are permitted regardless of ap_start; a send of a last word SHALL return to IDLE.
- Dropping ap_start therefore stops traffic only at a packet boundary.
REQ-022 Latency: a word written at edge N into an empty FIFO, with credit available and the FSM permitting, SHALL appear on out_link after edge N+1.
REQ-023 The credit counter SHALL be FSM-independent, of width clog2(CREDITS+1):
- decrement by 1 on a send;
- increment by 1 on credit_in;
- a send and credit_in in the same cycle SHALL leave it unchanged.
REQ-024 credit_in while the counter is at CREDITS with no same-cycle send SHALL leave the counter at CREDITS and set credit_err, which stays set until reset.
REQ-025 A simultaneous FIFO write and pop when full SHALL not be allowed, because in_ready is low; a simultaneous write and pop when non-full SHALL keep occupancy constant.
REQ-026 FIFO read and write pointers SHALL wrap modulo 2^FIFO_AW, with one extra bit for the full/empty distinction.

Reset
REQ-027 While reset is high, the block SHALL hold:
- out_link = 0, in_ready = 0, busy = 0, credit_err = 0, tx_count = 0;
- FIFO empty, FSM in IDLE, credits = CREDITS.
REQ-028 After reset deasserts, in_ready SHALL rise after the first clock edge.
REQ-029 Reset asserted mid-packet SHALL discard the FIFO contents and the partial packet immediately, with no further link words.

Configuration
REQ-030 With macro PE_LINK_TX_STATS_EN defined, tx_count SHALL increment by 1 on each send and wrap at 2^32.
REQ-031 Without PE_LINK_TX_STATS_EN, tx_count SHALL be tied to 0 and no counter SHALL be synthesized.

Structure
REQ-032 Package pe_link_pkg SHALL hold LINK_VALID_BIT, LINK_LAST_BIT, the default LINK_WIDTH and the FSM state enum (IDLE, PKT).
REQ-033 The FIFO SHALL be a separate sub-module, pe_link_fifo, parameterized by data width and FIFO_AW; the FSM, credit counter and output register SHALL stay in pe_link_tx.

Verification
REQ-034 Single word, ap_start = 1: write payload 0xA5 with last = 1 at edge N -> out_link = {1,1,0xA5} during cycle N+1 to N+2, then 0; credits 4 -> 3.
REQ-035 Credit stall: send 4 single-word packets with no credit_in, then a fifth -> the fifth is held and busy = 1; pulse credit_in -> the fifth is sent on the next cycle.
REQ-036 Packet boundary: 3-word packet, ap_start dropped after word 1 -> words 2 and 3 are still sent; a following packet is not sent until ap_start = 1.
REQ-037 FIFO full: 5 back-to-back writes with credits = 0 -> in_ready = 0 after the 4th write; the 5th word is accepted only after a pop.
REQ-038 Credit overflow and simultaneity: credit_in at credits = 4 -> credit_err = 1 and credits stays 4; credit_in coincident with a send -> count unchanged.
REQ-039 Reset mid-packet after word 1 of 3 -> out_link = 0, credits = 4, FIFO empty; with STATS_EN, tx_count = 0.

Source files
------------

// File: rtl/pe_link_pkg.sv
// pe_link_pkg -- shared definitions for the inter-PE link transmitter.
//   LINK_WIDTH_DEF : default link word width
//   LINK_VALID_BIT : valid bit position for the default width
//   LINK_LAST_BIT  : last-word bit position for the default width
//   link_state_t   : transmitter FSM states (IDLE, PKT)
package pe_link_pkg;

  localparam int LINK_WIDTH_DEF = 130;
  localparam int LINK_VALID_BIT = LINK_WIDTH_DEF - 1;
  localparam int LINK_LAST_BIT  = LINK_WIDTH_DEF - 2;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } link_state_t;

endpackage

// File: rtl/pe_link_fifo.sv
// pe_link_fifo -- ingress FIFO, depth 2**AW, combinational head read.
//   clk, reset : clock, asynchronous active-high reset
//   wr_en      : push wr_data (ignored while full)
//   wr_data    : word to push
//   rd_en      : pop the head (ignored while empty)
//   rd_data    : current head word
//   full/empty : occupancy flags
module pe_link_fifo
  import pe_link_pkg::*;
#(
  parameter int DW = LINK_WIDTH_DEF - 1,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2**AW];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_wr;
  logic        do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pe_link_tx.sv
// pe_link_tx -- credit-based inter-PE link transmitter.
// Optional feature: define PE_LINK_TX_STATS_EN to build the sent-word counter.
//   clk, reset : clock, asynchronous active-high reset
//   ap_start   : allows new packets to start
//   in_data    : payload word, in_last marks the final word, in_valid qualifies
//   in_ready   : FIFO can accept a word
//   credit_in  : one-cycle pulse, receiver freed a slot
//   out_link   : registered link word {valid, last, payload}
//   busy       : FIFO non-empty or mid-packet
//   credit_err : sticky credit overflow flag
//   tx_count   : words sent (0 without PE_LINK_TX_STATS_EN)
//
// state | meaning
// IDLE  | between packets; a send needs ap_start
// PKT   | inside a packet; sends continue regardless of ap_start
module pe_link_tx
  import pe_link_pkg::*;
#(
  parameter int LINK_WIDTH = LINK_WIDTH_DEF,
  parameter int FIFO_AW    = 2,
  parameter int CREDITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [LINK_WIDTH-3:0] in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  credit_in,
  output logic [LINK_WIDTH-1:0] out_link,
  output logic                  busy,
  output logic                  credit_err,
  output logic [31:0]           tx_count
);

  localparam int DW = LINK_WIDTH - 1;
  localparam int CW = $clog2(CREDITS + 1);
  // Package bit positions are for the default width; shift them with the width.
  localparam int VALID_BIT = LINK_VALID_BIT + (LINK_WIDTH - LINK_WIDTH_DEF);
  localparam int LAST_BIT  = LINK_LAST_BIT + (LINK_WIDTH - LINK_WIDTH_DEF);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  link_state_t           state;
  logic [CW-1:0]         credits;
  logic                  rdy_en;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  wr_en;
  logic                  send;
  logic                  head_last;
  logic [DW-1:0]         head;
  logic [LINK_WIDTH-1:0] link_d;

  pe_link_fifo #(
    .DW(DW),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data({in_last, in_data}),
    .rd_en  (send),
    .rd_data(head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // rdy_en keeps in_ready low during reset and until the first edge after it.
  assign in_ready  = rdy_en & ~fifo_full;
  assign wr_en     = in_valid & in_ready;
  assign head_last = head[LAST_BIT];
  assign send      = ~fifo_empty & (credits != '0) & ((state == PKT) | ap_start);
  assign busy      = ~fifo_empty | (state == PKT);

  always_comb begin
    link_d = '0;
    if (send) begin
      link_d[VALID_BIT]    = 1'b1;
      link_d[LAST_BIT:0]   = head;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out_link   <= '0;
      credits    <= CREDIT_MAX;
      credit_err <= 1'b0;
      rdy_en     <= 1'b0;
    end else begin
      rdy_en   <= 1'b1;
      out_link <= link_d;
      // Any sent word decides packet position: last closes, non-last opens/continues.
      if (send) state <= head_last ? IDLE : PKT;
      case ({send, credit_in})
        2'b10: credits <= credits - CW'(1);
        2'b01: begin
          if (credits == CREDIT_MAX) credit_err <= 1'b1;
          else                       credits    <= credits + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PE_LINK_TX_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tx_count <= '0;
    else if (send) tx_count <= tx_count + 32'd1;
  end
`else
  assign tx_count = '0;
`endif

endmodule

// File: tb/tb_pe_link_tx.sv
// tb_pe_link_tx -- self-checking bench for pe_link_tx: vector table,
// directed multi-cycle sequences and randomized traffic against a queue model.
module tb_pe_link_tx;
  import pe_link_pkg::*;

  localparam int LW = 130;
  localparam int PW = LW - 2;
  localparam int DEPTH = 4;
  localparam int CR = 4;
`ifdef PE_LINK_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ap_start = 1'b0;
  logic [PW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          credit_in = 1'b0;
  logic [LW-1:0] out_link;
  logic          busy;
  logic          credit_err;
  logic [31:0]   tx_count;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_link_tx #(.LINK_WIDTH(LW), .FIFO_AW(2), .CREDITS(CR)) dut (
    .clk       (clk),
    .reset     (reset),
    .ap_start  (ap_start),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .credit_in (credit_in),
    .out_link  (out_link),
    .busy      (busy),
    .credit_err(credit_err),
    .tx_count  (tx_count)
  );

  // Reference model: a queue of {last, payload}, an integer credit pool,
  // and "inside a packet" meaning the last word sent was not a last word.
  logic [PW:0]   mq[$];
  int            m_cr;
  bit            m_pkt;
  bit            m_err;
  bit            m_rdy;
  int unsigned   m_sent;
  logic [LW-1:0] m_out;

  typedef struct {
    logic ap, v, l;
    logic [7:0] p;
    logic ci;
    logic ov, ol;
    logic [7:0] op;
    logic rdy, bsy, err;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [LW-1:0] mk(logic v, logic l, logic [PW-1:0] p);
    logic [LW-1:0] w;
    w = '0;
    w[LINK_VALID_BIT] = v;
    w[LINK_LAST_BIT]  = l;
    w[PW-1:0]         = p;
    return w;
  endfunction

  task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic ap, logic v, logic l, logic [PW-1:0] p, logic ci);
    ap_start  = ap;
    in_valid  = v;
    in_last   = l;
    in_data   = p;
    credit_in = ci;
  endtask

  function automatic void model_reset();
    mq.delete();
    m_cr   = CR;
    m_pkt  = 1'b0;
    m_err  = 1'b0;
    m_rdy  = 1'b0;
    m_sent = 0;
    m_out  = '0;
  endfunction

  // Advance one clock with the inputs currently driven, then compare every output.
  task automatic cycle();
    bit          snd;
    bit          rdy_pre;
    logic [PW:0] w;
    rdy_pre = m_rdy && (mq.size() < DEPTH);
    snd     = (mq.size() > 0) && (m_cr > 0) && (m_pkt || (ap_start == 1'b1));
    m_out   = '0;
    if (snd) begin
      w      = mq.pop_front();
      m_out  = {1'b1, w};
      m_pkt  = !w[PW];
      m_sent = m_sent + 1;
    end
    if (in_valid && rdy_pre) mq.push_back({in_last, in_data});
    m_cr = m_cr - int'(snd) + int'(credit_in);
    if (m_cr > CR) begin
      m_cr  = CR;
      m_err = 1'b1;
    end
    m_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("out_link", out_link, m_out);
    chk("in_ready", LW'(in_ready), LW'(m_rdy && (mq.size() < DEPTH)));
    chk("busy", LW'(busy), LW'((mq.size() > 0) || m_pkt));
    chk("credit_err", LW'(credit_err), LW'(m_err));
    chk("tx_count", LW'(tx_count), STATS ? LW'(m_sent) : '0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    #2;
    chk("rst_out_link", out_link, '0);
    chk("rst_in_ready", LW'(in_ready), '0);
    chk("rst_busy", LW'(busy), '0);
    chk("rst_credit_err", LW'(credit_err), '0);
    chk("rst_tx_count", LW'(tx_count), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_out", out_link, '0);
    chk("rst_hold_ready", LW'(in_ready), '0);
    reset = 1'b0;
    model_reset();
    chk("rst_release_ready_low", LW'(in_ready), '0);
    cycle();
  endtask

  task automatic run_random(int n, int ap_pct, int v_pct, int l_pct, int ci_pct);
    for (int k = 0; k < n; k++) begin
      drive($urandom_range(99) < ap_pct, $urandom_range(99) < v_pct,
            $urandom_range(99) < l_pct, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(99) < ci_pct);
      cycle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          tbl_sent;
    int          nout;
    logic [PW-1:0] lastp;

    //            ap  v   l   pay    ci | ov  ol  opay   rdy bsy err
    tbl[0]  = '{1'b1,1'b1,1'b1,8'hA5,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b1,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b1,8'hA5,1'b1,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b1,8'h01,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b1,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b1,8'h02,1'b0, 1'b1,1'b1,8'h01,1'b1,1'b1,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b1,8'h03,1'b0, 1'b1,1'b1,8'h02,1'b1,1'b1,1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b1,8'h04,1'b0, 1'b1,1'b1,8'h03,1'b1,1'b1,1'b0};
    tbl[7]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b1,1'b0};
    tbl[8]  = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b1,1'b1,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b0,8'h00,1'b0, 1'b1,1'b1,8'h04,1'b1,1'b0,1'b0};
    tbl[10] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b1,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b1,1'b0,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b1,1'b0,1'b0};
    tbl[13] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b1,1'b0,1'b0};
    tbl[14] = '{1'b1,1'b1,1'b1,8'h11,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b1,1'b0};
    tbl[15] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b1,1'b1,8'h11,1'b1,1'b0,1'b0};
    tbl[16] = '{1'b1,1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b1,1'b0,1'b1};
    tbl[17] = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b0,1'b1};

    // Vector table: single word, credit stall and release, simultaneity, overflow.
    do_reset();
    tbl_sent = 0;
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].ap, tbl[i].v, tbl[i].l, PW'(tbl[i].p), tbl[i].ci);
      cycle();
      tbl_sent += int'(tbl[i].ov);
      chk($sformatf("tbl%0d_out", i), out_link, mk(tbl[i].ov, tbl[i].ol, PW'(tbl[i].op)));
      chk($sformatf("tbl%0d_ready", i), LW'(in_ready), LW'(tbl[i].rdy));
      chk($sformatf("tbl%0d_busy", i), LW'(busy), LW'(tbl[i].bsy));
      chk($sformatf("tbl%0d_err", i), LW'(credit_err), LW'(tbl[i].err));
      chk($sformatf("tbl%0d_txcnt", i), LW'(tx_count), STATS ? LW'(tbl_sent) : '0);
    end

    // Packet boundary: ap_start dropped mid-packet.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, PW'(8'h21), 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, PW'(8'h22), 1'b0); cycle();
    chk("pkt_w1", out_link, mk(1'b1, 1'b0, PW'(8'h21)));
    drive(1'b0, 1'b1, 1'b1, PW'(8'h23), 1'b0); cycle();
    chk("pkt_w2", out_link, mk(1'b1, 1'b0, PW'(8'h22)));
    drive(1'b0, 1'b1, 1'b1, PW'(8'h31), 1'b0); cycle();
    chk("pkt_w3", out_link, mk(1'b1, 1'b1, PW'(8'h23)));
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("pkt_next_held", out_link, '0);
      chk("pkt_next_busy", LW'(busy), LW'(1'b1));
    end
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0); cycle();
    chk("pkt_next_sent", out_link, mk(1'b1, 1'b1, PW'(8'h31)));

    // FIFO full with no credits.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b1, PW'(k), 1'b0); cycle();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0); cycle(); cycle();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b1, PW'(32'h50 + k), 1'b0); cycle();
      if (k == 3) chk("full_after_4th", LW'(in_ready), '0);
    end
    chk("full_5th_held", LW'(in_ready), '0);
    drive(1'b1, 1'b1, 1'b1, PW'(8'h54), 1'b1); cycle();
    chk("full_credit_only", LW'(in_ready), '0);
    drive(1'b1, 1'b1, 1'b1, PW'(8'h54), 1'b0); cycle();
    chk("full_pop_word", out_link, mk(1'b1, 1'b1, PW'(8'h50)));
    chk("full_ready_after_pop", LW'(in_ready), LW'(1'b1));
    drive(1'b1, 1'b1, 1'b1, PW'(8'h54), 1'b0); cycle();
    chk("full_5th_accepted", LW'(in_ready), '0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    nout = 0;
    lastp = '0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (out_link[LINK_VALID_BIT]) begin
        nout++;
        lastp = out_link[PW-1:0];
      end
    end
    chk("full_drain_count", LW'(nout), LW'(4));
    chk("full_drain_last", LW'(lastp), LW'(8'h54));

    // Reset in the middle of a 3-word packet.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, PW'(8'h61), 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, PW'(8'h62), 1'b0); cycle();
    chk("mid_w1", out_link, mk(1'b1, 1'b0, PW'(8'h61)));
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_out", out_link, '0);
    chk("mid_rst_busy", LW'(busy), '0);
    chk("mid_rst_ready", LW'(in_ready), '0);
    chk("mid_rst_txcnt", LW'(tx_count), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("mid_no_words", out_link, '0);
      chk("mid_fifo_empty", LW'(busy), '0);
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1); cycle();
    chk("mid_credits_full", LW'(credit_err), LW'(1'b1));

    // Randomized traffic against the model.
    do_reset();
    run_random(3000, 75, 60, 30, 20);
    do_reset();
    run_random(1000, 30, 70, 50, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
